// File: rtl/injection_controller.sv
// Traffic injection controller: Bernoulli packet injection toward a random destination
// node, with a valid/ready offer stage and an optional packet budget.
module injection_controller #(
  parameter int BITS       = 32,
  parameter int ADDR_BITS  = 4,
  parameter int COUNT_BITS = 16,
  parameter int SELF_ADDR  = 0,
  parameter int MAX_PKTS   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send,
  // "rand" is a reserved SystemVerilog keyword, hence rand_word
  input  logic [BITS-1:0]       rand_word,
  input  logic [7:0]            rate,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_BITS-1:0]  out_dest,
  output logic [COUNT_BITS-1:0] out_seq,
  output logic [COUNT_BITS-1:0] sent_count,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, OFFER, DONE} state_t;

  localparam logic [ADDR_BITS-1:0]  SELF      = ADDR_BITS'(SELF_ADDR);
  localparam logic [ADDR_BITS-1:0]  SELF_NEXT = ADDR_BITS'(SELF_ADDR + 1);
  localparam logic [COUNT_BITS-1:0] BUDGET    = COUNT_BITS'(MAX_PKTS);
  localparam bit                    LIMITED   = (MAX_PKTS != 0);

  state_t                state, state_next;
  logic [ADDR_BITS-1:0]  rand_dest, pick_dest;
  logic [COUNT_BITS-1:0] count_inc;
  logic                  capture, accept, budget_hit, budget_hit_inc;
  logic                  unused_rand;

  assign unused_rand    = ^rand_word[BITS-1:ADDR_BITS+8];
  assign rand_dest      = rand_word[ADDR_BITS+7:8];
  // A node never sends to itself; bump to the next address instead
  assign pick_dest      = (rand_dest == SELF) ? SELF_NEXT : rand_dest;
  assign count_inc      = sent_count + COUNT_BITS'(1);
  assign budget_hit     = LIMITED && (sent_count == BUDGET);
  assign budget_hit_inc = LIMITED && (count_inc == BUDGET);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: if (send) state_next = RUN;
      RUN: begin
        if (!send || budget_hit) begin
          state_next = DONE;
        end else if (rand_word[7:0] < rate) begin
          state_next = OFFER;
          capture    = 1'b1;
        end
      end
      // An offered packet always completes, even if send falls meanwhile
      OFFER: begin
        if (out_ready) begin
          accept     = 1'b1;
          state_next = (send && !budget_hit_inc) ? RUN : DONE;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_dest   <= '0;
      out_seq    <= '0;
      sent_count <= '0;
    end else begin
      if (capture) begin
        out_dest <= pick_dest;
        out_seq  <= sent_count;
      end
      if (accept) sent_count <= count_inc;
    end
  end

  assign out_valid = (state == OFFER);
  assign busy      = (state == RUN) || (state == OFFER);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_injection_controller.sv
// Self-checking bench: three parameterisations share one stimulus stream and are
// compared every cycle against a packet-level model, plus directed literal checks.
module tb_injection_controller;

  logic        clk = 1'b0;
  logic        reset, send, out_ready;
  logic [31:0] rnd;
  logic [7:0]  rate;

  logic [2:0]       vld, bsy, dn;
  logic [2:0][3:0]  dst;
  logic [2:0][15:0] sq, cnt;

  int errors = 0;
  int checks = 0;
  bit primed = 1'b0;

  always #5 clk = ~clk;

  injection_controller #(.SELF_ADDR(0), .MAX_PKTS(0)) dut0 (
    .clk(clk), .reset(reset), .send(send), .rand_word(rnd), .rate(rate),
    .out_valid(vld[0]), .out_ready(out_ready), .out_dest(dst[0]), .out_seq(sq[0]),
    .sent_count(cnt[0]), .busy(bsy[0]), .done(dn[0]));

  injection_controller #(.SELF_ADDR(3), .MAX_PKTS(0)) dut1 (
    .clk(clk), .reset(reset), .send(send), .rand_word(rnd), .rate(rate),
    .out_valid(vld[1]), .out_ready(out_ready), .out_dest(dst[1]), .out_seq(sq[1]),
    .sent_count(cnt[1]), .busy(bsy[1]), .done(dn[1]));

  injection_controller #(.SELF_ADDR(15), .MAX_PKTS(3)) dut2 (
    .clk(clk), .reset(reset), .send(send), .rand_word(rnd), .rate(rate),
    .out_valid(vld[2]), .out_ready(out_ready), .out_dest(dst[2]), .out_seq(sq[2]),
    .sent_count(cnt[2]), .busy(bsy[2]), .done(dn[2]));

  // Packet-level view of one node: has it started, finished, or got a packet outstanding
  typedef struct {
    bit started;
    bit finished;
    bit pending;
    int dest;
    int seq;
    int sent;
  } model_t;

  model_t m[3];
  int self_a[3] = '{0, 3, 15};
  int max_p[3]  = '{0, 0, 3};

  function automatic model_t step(input model_t s, input bit rst, input bit snd,
                                  input logic [31:0] r, input logic [7:0] rt,
                                  input bit rdy, input int self_addr, input int max_pkts);
    model_t n = s;
    int d;
    if (rst) begin
      n = '{0, 0, 0, 0, 0, 0};
    end else if (s.finished) begin
      n = s;
    end else if (!s.started) begin
      n.started = snd;
    end else if (s.pending) begin
      if (rdy) begin
        n.sent    = (s.sent + 1) % 65536;
        n.pending = 0;
        if (!snd || (max_pkts != 0 && n.sent == max_pkts)) n.finished = 1;
      end
    end else if (!snd || (max_pkts != 0 && s.sent == max_pkts)) begin
      n.finished = 1;
    end else if (int'(r[7:0]) < int'(rt)) begin
      d = int'(r[11:8]);
      if (d == self_addr) d = (self_addr + 1) % 16;
      n.pending = 1;
      n.dest    = d;
      n.seq     = s.sent;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input bit s, input logic [7:0] rt, input logic [31:0] r, input bit rdy);
    send      = s;
    rate      = rt;
    rnd       = r;
    out_ready = rdy;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  always @(posedge clk) begin
    if (reset) primed = 1'b1;
    for (int k = 0; k < 3; k++)
      m[k] = step(m[k], reset, send, rnd, rate, out_ready, self_a[k], max_p[k]);
  end

  always @(negedge clk) begin
    if (primed) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("dut%0d.out_valid", k), 32'(vld[k]), 32'(m[k].pending));
        checkOutput($sformatf("dut%0d.busy", k), 32'(bsy[k]), 32'(m[k].started && !m[k].finished));
        checkOutput($sformatf("dut%0d.done", k), 32'(dn[k]), 32'(m[k].finished));
        checkOutput($sformatf("dut%0d.sent_count", k), 32'(cnt[k]), m[k].sent);
        checkOutput($sformatf("dut%0d.out_dest", k), 32'(dst[k]), m[k].dest);
        checkOutput($sformatf("dut%0d.out_seq", k), 32'(sq[k]), m[k].seq);
      end
    end
  end

  initial begin
    int hs;
    int vcount;
    reset = 1'b1;
    applyStimulus(0, 8'h00, 32'h0, 0);
    doReset();
    checkOutput("reset_valid", 32'(vld[0]), 0);
    checkOutput("reset_busy", 32'(bsy[0]), 0);
    checkOutput("reset_done", 32'(dn[0]), 0);

    // Basic single packet: decision one cycle after entering RUN
    applyStimulus(1, 8'h80, 32'h510, 1);
    tick(1);
    checkOutput("s1_busy_in_run", 32'(bsy[0]), 1);
    checkOutput("s1_valid_in_run", 32'(vld[0]), 0);
    tick(1);
    checkOutput("s1_valid", 32'(vld[0]), 1);
    checkOutput("s1_dest", 32'(dst[0]), 5);
    checkOutput("s1_seq", 32'(sq[0]), 0);
    checkOutput("s1_dest_self3", 32'(dst[1]), 5);
    tick(1);
    checkOutput("s1_sent_after_accept", 32'(cnt[0]), 1);
    checkOutput("s1_valid_after_accept", 32'(vld[0]), 0);

    // Self-address avoidance
    doReset();
    applyStimulus(1, 8'h80, 32'h310, 0);
    tick(2);
    checkOutput("self3_dest", 32'(dst[1]), 4);
    checkOutput("self0_dest_3", 32'(dst[0]), 3);
    doReset();
    applyStimulus(1, 8'h80, 32'hF10, 0);
    tick(2);
    checkOutput("self15_dest", 32'(dst[2]), 0);
    checkOutput("self0_dest_15", 32'(dst[0]), 15);

    // Backpressure hold with send dropped mid-offer
    doReset();
    applyStimulus(1, 8'h80, 32'h710, 0);
    tick(2);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) send = 1'b0;
      rnd = $urandom;
      tick(1);
      checkOutput("hold_valid", 32'(vld[0]), 1);
      checkOutput("hold_dest", 32'(dst[0]), 7);
      checkOutput("hold_seq", 32'(sq[0]), 0);
    end
    out_ready = 1'b1;
    tick(1);
    checkOutput("hold_sent", 32'(cnt[0]), 1);
    checkOutput("hold_done", 32'(dn[0]), 1);
    checkOutput("hold_busy", 32'(bsy[0]), 0);

    // Budget of 3 packets on dut2
    doReset();
    applyStimulus(1, 8'hFF, 32'h200, 1);
    hs = 0;
    for (int i = 0; i < 20; i++) begin
      if (vld[2]) begin
        checkOutput("budget_seq", 32'(sq[2]), hs);
        hs++;
      end
      tick(1);
    end
    checkOutput("budget_handshakes", hs, 3);
    checkOutput("budget_done", 32'(dn[2]), 1);
    checkOutput("budget_sent", 32'(cnt[2]), 3);
    checkOutput("model_budget_sent", m[2].sent, 3);
    checkOutput("unlimited_busy", 32'(bsy[0]), 1);

    // Zero rate and saturated random byte never inject
    doReset();
    applyStimulus(1, 8'h00, 32'h0, 1);
    vcount = 0;
    for (int i = 0; i < 100; i++) begin
      rnd = $urandom;
      tick(1);
      vcount += int'(vld[0]) + int'(vld[1]) + int'(vld[2]);
    end
    checkOutput("rate0_valids", vcount, 0);
    checkOutput("rate0_sent", 32'(cnt[0]), 0);
    doReset();
    applyStimulus(1, 8'hFF, 32'h0FF, 1);
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      rnd = ($urandom & 32'hFFFF_FF00) | 32'hFF;
      tick(1);
      vcount += int'(vld[0]) + int'(vld[1]) + int'(vld[2]);
    end
    checkOutput("randFF_valids", vcount, 0);

    // Reset while a packet is offered discards it
    doReset();
    applyStimulus(1, 8'h80, 32'h410, 1);
    tick(3);
    out_ready = 1'b0;
    tick(1);
    checkOutput("rst_offer_valid", 32'(vld[0]), 1);
    checkOutput("rst_offer_seq", 32'(sq[0]), 1);
    reset = 1'b1;
    tick(1);
    checkOutput("rst_valid", 32'(vld[0]), 0);
    checkOutput("rst_sent", 32'(cnt[0]), 0);
    checkOutput("rst_busy", 32'(bsy[0]), 0);
    reset = 1'b0;
    out_ready = 1'b1;
    tick(2);
    checkOutput("restart_valid", 32'(vld[0]), 1);
    checkOutput("restart_seq", 32'(sq[0]), 0);

    // Mixed random traffic with occasional resets, checked by the model
    doReset();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      send  = ($urandom_range(0, 9) != 0);
      rate  = 8'($urandom);
      rnd   = $urandom;
      if ($urandom_range(0, 7) == 0) rnd[7:0] = 8'hFF;
      else if ($urandom_range(0, 7) == 0) rnd[7:0] = rate;
      out_ready = 1'($urandom_range(0, 1));
      tick(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
